rmst_arbiter: RTL and testbench
===============================

# rmst_arbiter

Shares the single AXI read-master transaction port between the tile load controllers (weight loader, input-feature loader, ...). Each controller issues one burst request at a time (byte address plus word length). The arbiter queues one pending request per requester and grants them round-robin. It drives the master's start/length/address, waits for the master's completion, and returns a done pulse to the owning requester. It also publishes the grant id so the read-data path can steer returned words into the right load FIFO.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4)
- XAW, 32: external byte-address width
- CW, 16: burst length width (words)
- IDW, 2: grant id width, ≥ clog2(NREQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_start  in  NREQ  per-requester one-cycle request pulse
- req_raddr  in  NREQ*XAW  request byte address; slice i = [i*XAW +: XAW]; sampled with req_start[i]
- req_iolen  in  NREQ*CW  request length in words; slice i; sampled with req_start[i]
- req_done  out  NREQ  one-cycle completion pulse to requester i
- mst_raddr  out  XAW  address to read master
- mst_iolen  out  CW  length to read master
- mst_trans_start  out  1  one-cycle start pulse to read master
- mst_trans_done  in  1  one-cycle completion pulse from read master
- gnt_id  out  IDW  requester owning the current/last transaction
- gnt_valid  out  1  high from the mst_trans_start cycle until mst_trans_done is accepted
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Per requester i: pending[i], addr_q[i], len_q[i]. A req_start[i] pulse with pending[i]==0 and i not in flight captures address and length, and sets pending[i].
- A req_start[i] while pending[i] or while i is in flight is dropped, sets proto_err, and leaves the queued request unchanged. proto_err clears only on reset.
- FSM, registered, 3-bit encoding:
  - IDLE: if any pending, pick winner w = first pending at or after rr_ptr (cyclic). Load mst_raddr=addr_q[w], mst_iolen=len_q[w], gnt_id=w. Go to ISSUE, or go to RETIRE if len_q[w]==0.
  - ISSUE: mst_trans_start=1 and gnt_valid=1. Go to BUSY.
  - BUSY: gnt_valid=1. On mst_trans_done go to RETIRE.
  - RETIRE: req_done[gnt_id]=1, clear pending[gnt_id], rr_ptr=gnt_id+1 (wraps at NREQ to 0). Go to IDLE.
- Zero-length requests never touch the master: no mst_trans_start, and req_done pulses on the second cycle after the request is captured.
- mst_trans_done outside BUSY is ignored; no proto_err.
- Address and length pass through unmodified; no width arithmetic. rr_ptr is IDW bits and compares modulo NREQ.
- Requests arriving while BUSY queue up and are arbitrated at the next IDLE.

## Timing
- All outputs are registered. Reset values: req_done=0, mst_raddr=0, mst_iolen=0, mst_trans_start=0, gnt_id=0, gnt_valid=0, proto_err=0, rr_ptr=0, pending=0, state=IDLE.
- Uncontended latency:
  - req_start sampled on edge t; pending visible after t.
  - IDLE picks at edge t+1.
  - mst_trans_start is high in the cycle after edge t+1 (second cycle after the request cycle).
- Completion: mst_trans_done sampled on edge d; req_done high in the cycle after d; the arbiter is back in IDLE one cycle later.
- Back-to-back: a new grant cannot start before the cycle after RETIRE. Minimum gap between two mst_trans_start pulses is 3 cycles plus the master's busy time.
- A requester re-issuing in the same cycle as its req_done pulse is a protocol error; it may re-issue from the next cycle.
- Simultaneous req_start from several requesters: all are captured in the same cycle; service order is round-robin from rr_ptr.
- Deasserting rst_n mid-transfer aborts the arbiter state. The read master and requesters share rst_n and must abort too; no req_done is produced for the lost transfer.

## Structure
- Package rmst_arb_pkg holds the state localparams (IDLE=3'b000, ISSUE=3'b001, BUSY=3'b010, RETIRE=3'b011) and the NREQ upper bound (4).
- Sub-module rmst_rr_picker: a combinational cyclic priority picker. Inputs: pending vector and rr_ptr. Outputs: winner id and any_pending.
- Top level holds the capture registers, the FSM, and the output registers.

## Test plan
- Single request: req0 raddr=0x0008_0000, iolen=144. Expect one mst_trans_start carrying exactly those values, 2 cycles after the request; gnt_id=0; req_done[0] one cycle after mst_trans_done.
- Contention: req0 and req1 pulse in the same cycle after reset. Expect grant order 0 then 1. Repeat the pair: order is 0 then 1 again, since rr_ptr returns to 0. gnt_valid spans each transfer exactly.
- Queue while busy: req1 arrives during req0's BUSY. Expect it served at the next IDLE; req1's captured address is unchanged even though req_raddr changes after the pulse.
- Zero length: req1 iolen=0. Expect no mst_trans_start and req_done[1] 2 cycles after the request.
- Protocol error: req0 issues again while pending. Expect proto_err=1 sticky and only one transfer for req0. A stray mst_trans_done in IDLE has no effect.
- Reset mid-BUSY: assert rst_n low. Expect all outputs at reset values immediately (async), pending cleared, and a normal grant after release.

Source files
------------

// File: rtl/rmst_arb_pkg.sv
// Shared constants for the read-master arbiter: FSM state codes and the
// largest supported requester count.
package rmst_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'b000;
  localparam state_t ISSUE  = 3'b001;
  localparam state_t BUSY   = 3'b010;
  localparam state_t RETIRE = 3'b011;

  localparam int NREQ_MAX = 4;

endpackage

// File: rtl/rmst_arbiter_if.sv
// Requester and read-master signal bundle for rmst_arbiter.
// "master" is the arbiter side; "slave" is the requesters plus read master.
interface rmst_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XAW  = 32,
  parameter int CW   = 16,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     req_start;
  logic [NREQ*XAW-1:0] req_raddr;
  logic [NREQ*CW-1:0]  req_iolen;
  logic [NREQ-1:0]     req_done;
  logic [XAW-1:0]      mst_raddr;
  logic [CW-1:0]       mst_iolen;
  logic                mst_trans_start;
  logic                mst_trans_done;
  logic [IDW-1:0]      gnt_id;
  logic                gnt_valid;

  modport master (
    input  req_start, req_raddr, req_iolen, mst_trans_done,
    output req_done, mst_raddr, mst_iolen, mst_trans_start, gnt_id, gnt_valid
  );

  modport slave (
    output req_start, req_raddr, req_iolen, mst_trans_done,
    input  req_done, mst_raddr, mst_iolen, mst_trans_start, gnt_id, gnt_valid
  );
endinterface

// File: rtl/rmst_rr_picker.sv
// Combinational cyclic priority picker: first pending requester at or after
// rr_ptr (taken modulo NREQ), wrapping around.
module rmst_rr_picker
  import rmst_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_pending
);

  int   base;
  int   idx;
  logic found;

  // Scan from the pointer position; the inner loop keeps every pending
  // index a constant after unrolling.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    base   = int'(rr_ptr) % NREQ;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < NREQ) begin
        idx = (base + k) % NREQ;
        for (int j = 0; j < NREQ; j++) begin
          if (!found && (j == idx) && pending[j]) begin
            found  = 1'b1;
            winner = IDW'(j);
          end
        end
      end
    end
  end

  assign any_pending = |pending;

endmodule

// File: rtl/rmst_arbiter.sv
// Round-robin arbiter sharing one AXI read-master port among tile load
// controllers. One queued request per requester; grant id steers read data.
//
//   state  | meaning
//   IDLE   | waiting; picks the next pending requester
//   ISSUE  | mst_trans_start pulse to the read master
//   BUSY   | transfer in progress, waiting for mst_trans_done
//   RETIRE | req_done to owner, clear its pending bit, advance rr_ptr
module rmst_arbiter
  import rmst_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XAW  = 32,
  parameter int CW   = 16,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rmst_arbiter_if.master       bus,
  output logic                 proto_err
);

  state_t          state, next_state;
  logic [NREQ-1:0] pending;
  logic [XAW-1:0]  addr_q [NREQ];
  logic [CW-1:0]   len_q  [NREQ];
  logic [IDW-1:0]  rr_ptr, winner, gid_d;
  logic            any_pending, pick;
  logic [NREQ-1:0] accept, in_flight, done_d;
  logic [XAW-1:0]  win_addr, raddr_d;
  logic [CW-1:0]   win_len, iolen_d;
  logic            start_d, gvalid_d;

  rmst_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .winner      (winner),
    .any_pending (any_pending)
  );

  // A request is accepted only when its slot is empty and it is not the
  // transaction currently owned by the master.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_flight[i] = (state != IDLE) && (bus.gnt_id == IDW'(i));
    end
    accept = bus.req_start & ~pending & ~in_flight;
  end

  // Select the queued address/length of the picker's winner.
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        win_addr = addr_q[i];
        win_len  = len_q[i];
      end
    end
  end

  // Capture registers, pending bits, round-robin pointer and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      proto_err <= proto_err | (|(bus.req_start & ~accept));
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          pending[i] <= 1'b1;
          addr_q[i]  <= bus.req_raddr[i*XAW +: XAW];
          len_q[i]   <= bus.req_iolen[i*CW +: CW];
        end else if ((state == RETIRE) && (bus.gnt_id == IDW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
      if (state == RETIRE) begin
        rr_ptr <= (int'(bus.gnt_id) + 1 >= NREQ) ? '0 : bus.gnt_id + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state; zero-length requests skip the master entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_pending) next_state = (win_len == '0) ? RETIRE : ISSUE;
      ISSUE:   next_state = BUSY;
      BUSY:    if (bus.mst_trans_done) next_state = RETIRE;
      RETIRE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output next values, derived from the upcoming state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    pick     = (state == IDLE) && any_pending;
    gid_d    = pick ? winner   : bus.gnt_id;
    raddr_d  = pick ? win_addr : bus.mst_raddr;
    iolen_d  = pick ? win_len  : bus.mst_iolen;
    start_d  = (next_state == ISSUE);
    gvalid_d = (next_state == ISSUE) || (next_state == BUSY);
    done_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((next_state == RETIRE) && (gid_d == IDW'(i))) done_d[i] = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_done        <= '0;
      bus.mst_raddr       <= '0;
      bus.mst_iolen       <= '0;
      bus.mst_trans_start <= 1'b0;
      bus.gnt_id          <= '0;
      bus.gnt_valid       <= 1'b0;
    end else begin
      bus.req_done        <= done_d;
      bus.mst_raddr       <= raddr_d;
      bus.mst_iolen       <= iolen_d;
      bus.mst_trans_start <= start_d;
      bus.gnt_id          <= gid_d;
      bus.gnt_valid       <= gvalid_d;
    end
  end

endmodule

// File: tb/tb_rmst_arbiter.sv
// Scoreboard bench for rmst_arbiter: directed requests push expected
// transfers/completions; a monitor pops and compares on DUT output events.
module tb_rmst_arbiter;

  localparam int NREQ = 2;
  localparam int XAW  = 32;
  localparam int CW   = 16;
  localparam int IDW  = 2;

  typedef struct {
    logic [XAW-1:0] a;
    logic [CW-1:0]  l;
    logic [IDW-1:0] id;
  } tx_t;

  logic clk = 1'b0;
  logic rst_n;
  logic proto_err;
  logic model_done = 1'b0;
  logic stray_done = 1'b0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_done = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int mdone_cyc = 0;
  int lat = 3;

  tx_t exp_tx[$];
  int  exp_done[$];

  rmst_arbiter_if #(.NREQ(NREQ), .XAW(XAW), .CW(CW), .IDW(IDW)) bus ();

  rmst_arbiter #(.NREQ(NREQ), .XAW(XAW), .CW(CW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .proto_err (proto_err)
  );

  assign bus.mst_trans_done = model_done | stray_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_tx(input logic [XAW-1:0] a, input logic [CW-1:0] l,
                                  input logic [IDW-1:0] id);
    tx_t t;
    t.a = a; t.l = l; t.id = id;
    exp_tx.push_back(t);
  endfunction

  task automatic set_req(input int i, input logic [XAW-1:0] a, input logic [CW-1:0] l);
    bus.req_raddr[i*XAW +: XAW] = a;
    bus.req_iolen[i*CW +: CW]   = l;
  endtask

  task automatic pulse(input logic [NREQ-1:0] m);
    bus.req_start = m;
    @(posedge clk); #1;
    bus.req_start = '0;
  endtask

  task automatic wait_start(input int target);
    int k = 0;
    while (n_start < target && k < 100) begin @(posedge clk); k++; end
    #1;
    if (n_start < target) begin
      checks++; failures++;
      $display("FAIL wait_start_timeout: got %0d starts expected %0d", n_start, target);
    end
  endtask

  task automatic wait_dones(input int target);
    int k = 0;
    while (n_done < target && k < 300) begin @(posedge clk); k++; end
    #1;
    if (n_done < target) begin
      checks++; failures++;
      $display("FAIL wait_done_timeout: got %0d completions expected %0d", n_done, target);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Read-master model: completes lat cycles into BUSY, aborts on reset.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mst_trans_start) begin
        k = 0;
        while (k < lat && rst_n) begin @(negedge clk); k++; end
        if (rst_n) begin
          @(posedge clk); #1;
          model_done = 1'b1;
          mdone_cyc  = cyc;
          @(posedge clk); #1;
          model_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations on start/done and checks gnt_valid framing.
  initial begin
    logic prev_gv, prev_md;
    tx_t  t;
    int   id;
    prev_gv = 1'b0;
    prev_md = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_gv = 1'b0;
        prev_md = 1'b0;
      end else begin
        if (bus.mst_trans_start) begin
          n_start++;
          start_cyc = cyc;
          if (exp_tx.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_start: got addr 0x%0h id %0d expected no transfer",
                     bus.mst_raddr, bus.gnt_id);
          end else begin
            t = exp_tx.pop_front();
            check("start_addr", 64'(bus.mst_raddr), 64'(t.a));
            check("start_len",  64'(bus.mst_iolen), 64'(t.l));
            check("start_id",   64'(bus.gnt_id),    64'(t.id));
          end
        end
        if (bus.req_done != '0) begin
          n_done++;
          done_cyc = cyc;
          if (exp_done.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done: got req_done 0x%0h expected none", bus.req_done);
          end else begin
            id = exp_done.pop_front();
            check("req_done_vec", 64'(bus.req_done), 64'(1) << id);
          end
        end
        if (bus.gnt_valid && !prev_gv) check("gv_rise_with_start", 64'(bus.mst_trans_start), 64'(1));
        if (!bus.gnt_valid && prev_gv) check("gv_fall_after_done", 64'(prev_md), 64'(1));
        prev_gv = bus.gnt_valid;
        prev_md = bus.mst_trans_done;
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got over 5000 cycles expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, ns, nd;
    bus.req_start = '0;
    bus.req_raddr = '0;
    bus.req_iolen = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_raddr",     64'(bus.mst_raddr),       64'(0));
    check("rst_iolen",     64'(bus.mst_iolen),       64'(0));
    check("rst_start",     64'(bus.mst_trans_start), 64'(0));
    check("rst_gnt_id",    64'(bus.gnt_id),          64'(0));
    check("rst_gnt_valid", 64'(bus.gnt_valid),       64'(0));
    check("rst_req_done",  64'(bus.req_done),        64'(0));
    check("rst_proto_err", 64'(proto_err),           64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // contention after reset: 0 then 1, twice
    set_req(0, 32'h0001_0000, 16'd4);
    set_req(1, 32'h0002_0000, 16'd5);
    push_tx(32'h0001_0000, 16'd4, 2'd0); push_tx(32'h0002_0000, 16'd5, 2'd1);
    exp_done.push_back(0); exp_done.push_back(1);
    pulse(2'b11);
    wait_dones(2);
    set_req(0, 32'h0003_0040, 16'd1);
    set_req(1, 32'h0004_0080, 16'd2);
    push_tx(32'h0003_0040, 16'd1, 2'd0); push_tx(32'h0004_0080, 16'd2, 2'd1);
    exp_done.push_back(0); exp_done.push_back(1);
    pulse(2'b11);
    wait_dones(4);

    // single request, latency checks
    set_req(0, 32'h0008_0000, 16'd144);
    push_tx(32'h0008_0000, 16'd144, 2'd0);
    exp_done.push_back(0);
    rc = cyc;
    pulse(2'b01);
    wait_dones(5);
    check("single_start_latency", 64'(start_cyc), 64'(rc + 2));
    check("single_done_latency",  64'(done_cyc),  64'(mdone_cyc + 1));
    check("single_gnt_id",        64'(bus.gnt_id), 64'(0));

    // rr_ptr now 1: simultaneous pair is served 1 then 0
    set_req(0, 32'h0005_0000, 16'd3);
    set_req(1, 32'h0006_0000, 16'd6);
    push_tx(32'h0006_0000, 16'd6, 2'd1); push_tx(32'h0005_0000, 16'd3, 2'd0);
    exp_done.push_back(1); exp_done.push_back(0);
    pulse(2'b11);
    wait_dones(7);

    // req1 arrives while req0 is busy; its address input changes afterwards
    set_req(0, 32'h0007_0100, 16'd8);
    push_tx(32'h0007_0100, 16'd8, 2'd0); push_tx(32'hCAFE_0000, 16'd9, 2'd1);
    exp_done.push_back(0); exp_done.push_back(1);
    ns = n_start;
    pulse(2'b01);
    wait_start(ns + 1);
    check("busy_when_queued", 64'(bus.gnt_valid), 64'(1));
    set_req(1, 32'hCAFE_0000, 16'd9);
    pulse(2'b10);
    set_req(1, 32'hDEAD_0000, 16'd11);
    wait_dones(9);

    // zero-length request never reaches the master
    set_req(1, 32'h0009_0000, 16'd0);
    exp_done.push_back(1);
    ns = n_start;
    rc = cyc;
    pulse(2'b10);
    wait_dones(10);
    check("zero_len_no_start",     64'(n_start),  64'(ns));
    check("zero_len_done_latency", 64'(done_cyc), 64'(rc + 2));

    // re-issue while pending is dropped and flagged
    check("proto_err_clear", 64'(proto_err), 64'(0));
    set_req(0, 32'h000A_0000, 16'd7);
    push_tx(32'h000A_0000, 16'd7, 2'd0);
    exp_done.push_back(0);
    ns = n_start;
    pulse(2'b01);
    set_req(0, 32'h000B_0000, 16'd2);
    pulse(2'b01);
    check("proto_err_set", 64'(proto_err), 64'(1));
    wait_dones(11);
    check("proto_single_transfer", 64'(n_start), 64'(ns + 1));

    // stray completion while idle is ignored
    nd = n_done;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_no_done",      64'(n_done),        64'(nd));
    check("stray_no_grant",     64'(bus.gnt_valid), 64'(0));
    check("proto_err_sticky",   64'(proto_err),     64'(1));

    // reset in the middle of a transfer
    lat = 20;
    set_req(0, 32'h000C_0000, 16'd64);
    push_tx(32'h000C_0000, 16'd64, 2'd0);
    ns = n_start;
    nd = n_done;
    pulse(2'b01);
    wait_start(ns + 1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", 64'(bus.gnt_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_gnt_valid", 64'(bus.gnt_valid),       64'(0));
    check("arst_raddr",     64'(bus.mst_raddr),       64'(0));
    check("arst_iolen",     64'(bus.mst_iolen),       64'(0));
    check("arst_gnt_id",    64'(bus.gnt_id),          64'(0));
    check("arst_start",     64'(bus.mst_trans_start), 64'(0));
    check("arst_req_done",  64'(bus.req_done),        64'(0));
    check("arst_proto_err", 64'(proto_err),           64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat = 3;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_regrant", 64'(n_start), 64'(ns + 1));
    check("post_rst_no_done",    64'(n_done),  64'(nd));
    set_req(1, 32'h000D_0000, 16'd12);
    push_tx(32'h000D_0000, 16'd12, 2'd1);
    exp_done.push_back(1);
    rc = cyc;
    pulse(2'b10);
    wait_dones(nd + 1);
    check("post_rst_start_latency", 64'(start_cyc), 64'(rc + 2));

    check("exp_tx_drained",   64'(exp_tx.size()),   64'(0));
    check("exp_done_drained", 64'(exp_done.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
